// File: rtl/cht_shift_bank.sv
// Multi-lane registered shift/rotate bank: LOAD, SHL, SHR and ROT at one bit per cycle.
// The rotate datapath is built only when CHT_SHIFT_ROTATE_EN is defined; otherwise op 11 is a no-op.
module cht_shift_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [AMT_W-1:0]       cmd_amt,
  input  logic [LANES-1:0]       cmd_mask,
  input  logic                   fill_bit,
  input  logic [LANES*WIDTH-1:0] load_data,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpShl  = 2'b01;
  localparam logic [1:0] OpShr  = 2'b10;
`ifdef CHT_SHIFT_ROTATE_EN
  localparam logic [1:0] OpRot  = 2'b11;
`endif

  state_e                        state_q, state_d;
  logic [AMT_W-1:0]              cnt_q, cnt_d;
  logic [1:0]                    op_q, op_d;
  logic [LANES-1:0]              mask_q, mask_d;
  logic                          fill_q, fill_d;
  logic [LANES-1:0][WIDTH-1:0]   data_q, data_d;
  logic [LANES-1:0][WIDTH-1:0]   step_val;

  logic             accept;
  logic             shift_op;
  logic [AMT_W-1:0] amt_sat;

  assign cmd_ready = (state_q == StIdle) & ~clr & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign amt_sat   = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;

  // Ops that take the multi-cycle SHIFT path; without the rotate feature op 11 finishes at once.
`ifdef CHT_SHIFT_ROTATE_EN
  assign shift_op = (cmd_op != OpLoad);
`else
  assign shift_op = (cmd_op == OpShl) | (cmd_op == OpShr);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpLoad;
      mask_q  <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (shift_op && (amt_sat != '0)) begin
            state_d = StShift;
            cnt_d   = amt_sat;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // One-bit step for every lane, applied only to masked lanes while shifting
  always_comb begin
    step_val = data_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (op_q)
        OpShl:   step_val[i] = {data_q[i][WIDTH-2:0], fill_q};
        OpShr:   step_val[i] = {fill_q, data_q[i][WIDTH-1:1]};
`ifdef CHT_SHIFT_ROTATE_EN
        OpRot:   step_val[i] = {data_q[i][0], data_q[i][WIDTH-1:1]};
`endif
        default: step_val[i] = data_q[i];
      endcase
    end
  end

  // Command capture and lane datapath
  always_comb begin
    op_d   = op_q;
    mask_d = mask_q;
    fill_d = fill_q;
    data_d = data_q;
    if (accept) begin
      op_d   = cmd_op;
      mask_d = cmd_mask;
      fill_d = fill_bit;
      if (cmd_op == OpLoad) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (cmd_mask[i]) begin
            data_d[i] = load_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
    if (state_q == StShift) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mask_q[i]) begin
          data_d[i] = step_val[i];
        end
      end
    end
    // Clear wins over any load or shift step in the same cycle.
    if (clr) begin
      data_d = '0;
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    data_out = data_q;
  end

endmodule

// File: doc/cht_shift_bank.md
Name: cht_shift_bank

Overview:
- Multi-lane registered shift/rotate bank. It is the sequential, parametrised successor to the combinational shift-by-one mux bank in the cht datapath.
- Holds LANES independent WIDTH-bit registers. Each register can be loaded, shifted left or right, or (optionally) rotated by a programmable amount, one bit per cycle.
- Commands arrive through a valid/ready handshake, with a per-lane enable mask and a synchronous clear equivalent to the legacy `l` kill input.
- Sits between the control sequencer and the downstream cht datapath consumers.

Parameters:
- WIDTH, 16: bits per lane; minimum 2.
- LANES, 4: number of independent lanes; minimum 1.
- AMT_W, $clog2(WIDTH)+1: width of the shift-amount field. Derived; do not override.

Ports:
- clk  in  1  : single clock, rising-edge.
- rst  in  1  : synchronous, active-high reset.
- clr  in  1  : synchronous clear of all lanes; also aborts the current operation.
- cmd_valid  in  1  : command present.
- cmd_ready  out  1  : bank can accept a command.
- cmd_op  in  2  : 00 LOAD, 01 SHL, 10 SHR, 11 ROT.
- cmd_amt  in  AMT_W  : shift amount, 0..WIDTH.
- cmd_mask  in  LANES  : lane enable; bit i selects lane i.
- fill_bit  in  1  : bit shifted into vacated positions during SHL/SHR.
- load_data  in  LANES*WIDTH  : LOAD data; lane i is bits [i*WIDTH +: WIDTH].
- data_out  out  LANES*WIDTH  : current lane registers.
- busy  out  1  : FSM not in IDLE.
- done  out  1  : one-cycle pulse when a command completes.

Behaviour:
- Reset (rst=1 at an edge):
  - data_out=0, state=IDLE, done=0, busy=0.
  - cmd_ready is low while rst is high.
  - rst overrides clr and any command.
- cmd_ready = (state==IDLE) & ~clr & ~rst. A command is accepted at an edge where cmd_valid & cmd_ready.
- On acceptance, op, amt, mask and fill_bit are captured into internal registers. Input changes after acceptance have no effect.
- FSM states: IDLE, SHIFT, DONE.
- LOAD, accepted at edge N:
  - At edge N, masked lanes take load_data and the FSM goes to DONE.
  - At edge N+1, done=1 for that cycle and the FSM returns to IDLE.
  - Unmasked lanes hold their value.
- SHL/SHR/ROT with amt=k>0, accepted at edge N:
  - FSM enters SHIFT with remaining-count=k.
  - Each SHIFT cycle moves every masked lane by one bit and decrements the count.
  - The lanes change at edges N+1 .. N+k. The FSM enters DONE at edge N+k.
  - done is high during the cycle after edge N+k. The next command can be accepted at edge N+k+2.
- Shift rules, per lane:
  - SHL: {lane[WIDTH-2:0], fill_bit}.
  - SHR: {fill_bit, lane[WIDTH-1:1]}.
  - ROT (right): {lane[0], lane[WIDTH-1:1]}.
- amt=0: goes directly to DONE with no data change (same timing as LOAD).
- amt=WIDTH:
  - SHL/SHR: lane is filled entirely with fill_bit.
  - ROT: lane is restored to its original value.
- amt>WIDTH saturates to WIDTH.
- cmd_mask=0: the command runs its full timing and pulses done, but no lane changes.
- clr=1 at an edge, with rst=0:
  - All lanes go to 0 and the FSM goes to IDLE.
  - An in-flight operation is aborted and no done pulse is issued for it.
  - clr has priority over any shift step scheduled in the same cycle.
- busy = (state != IDLE). done is high only in the DONE state.

Optional Feature:
- Macro: CHT_SHIFT_ROTATE_EN.
- When defined: op 11 performs ROT as described above.
- When undefined:
  - op 11 is accepted but acts as a no-op: no lane changes, and it goes straight to DONE regardless of amt.
  - The rotate datapath is not synthesised.

Test Plan (all cases use WIDTH=16, LANES=4):
- Reset then LOAD: rst held for 2 cycles, then LOAD mask=1111 with lanes 0x1234/0xABCD/0x0001/0x8000 -> data_out matches the loaded values one edge after acceptance; done pulses exactly one cycle; busy is low afterwards.
- SHL: amt=4, fill=0, mask=0001, lane0=0x1234 -> lane0=0x2340 after 4 shift edges, other lanes unchanged; done arrives 5 cycles after acceptance; cmd_ready is low for the whole operation.
- SHR: amt=16, fill=1, mask=0010 -> lane1=0xFFFF. Then SHR amt=20 -> saturates, lane1 stays 0xFFFF, and done arrives at the same time as for amt=16.
- ROT: amt=8, lane2=0x00FF -> 0xFF00 with CHT_SHIFT_ROTATE_EN defined; without the macro, lane2 stays 0x00FF and done arrives 1 cycle after acceptance.
- Abort: clr asserted on the 3rd cycle of an SHL amt=10 -> all lanes read 0 on the next edge; no done pulse; cmd_ready rises the cycle after clr drops.
- Back-to-back: cmd_valid held high with two LOADs -> the second command is accepted 2 cycles after the first; amt=0 SHL produces done with data unchanged.
